bit_serial_divider: RTL and testbench

BIT_SERIAL_DIVIDER -- requirements
Module: bit_serial_divider

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 50 +++++
 rtl/bit_serial_divider.sv | 199 +++++++++++++++++++
 tb/tb_bit_serial_divider.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared declarations for the bit-serial restoring divider.
//
// Contents:
//   DIV_N_DEFAULT  default operand width (divisor / quotient / remainder)
//   div_state_e    controller state encoding (IDLE, CALC, DONE)
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One iteration of restoring division, purely combinational.
//
// The {partial remainder, dividend} register is shifted left by one. The upper
// N+1 bits of the shifted value are compared against the divisor with an
// (N+1)-bit subtractor. If the difference is non-negative it becomes the new
// partial remainder and a 1 enters the quotient. Otherwise the shifted value
// is kept and a 0 enters the quotient.
//
// Parameters:
//   N        operand width
// Ports:
//   rem_i    partial remainder before this step         (N bits)
//   quo_i    remaining dividend bits / quotient so far   (N bits)
//   d_i      divisor                                     (N bits)
//   rem_o    partial remainder after this step           (N bits)
//   quo_o    dividend / quotient bits after this step    (N bits)
// -----------------------------------------------------------------------------
module div_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] rem_i,
    input  logic [N-1:0] quo_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] rem_o,
    output logic [N-1:0] quo_o
);

    logic [N:0] shifted_hi;
    logic [N:0] trial;
    logic       trial_nonneg;

    // Upper N+1 bits after the left shift: old remainder plus the next
    // dividend bit dropping in from below.
    assign shifted_hi = {rem_i, quo_i[N-1]};

    // (N+1)-bit subtract, wrapping modulo 2^(N+1).
    assign trial = shifted_hi - {1'b0, d_i};

    // If the shifted value has its top bit set, it is at least 2^N, which
    // exceeds any N-bit divisor, so the true difference is positive even
    // though the wrapped result may show bit N set. Otherwise both operands
    // are below 2^N and bit N of the wrapped result is a true sign bit.
    assign trial_nonneg = shifted_hi[N] | ~trial[N];

    assign rem_o = trial_nonneg ? trial[N-1:0] : shifted_hi[N-1:0];
    assign quo_o = {quo_i[N-2:0], trial_nonneg};

endmodule : div_step

// File: rtl/bit_serial_divider.sv
// -----------------------------------------------------------------------------
// bit_serial_divider
// Unsigned restoring divider: a 2N-bit dividend divided by an N-bit divisor,
// producing one quotient bit per clock, MSB first, with N cycles of latency.
//
// Handshake: start is sampled on a rising edge while the controller is in IDLE
// or DONE. On that edge z and d are captured and done/overflow are cleared.
// Start is ignored while busy. done rises on the edge that completes the last
// quotient bit and stays high, with q and r held, until the next accepted
// start or reset. A start held high in DONE begins the next division on the
// same edge that drops done.
//
// Optional feature (macro DIV_OVF_CHECK_EN): when defined, the upper half of
// the dividend is compared against the divisor at start. If z[2N-1:N] >= d
// (which includes d == 0), the quotient cannot fit in N bits. The block then
// moves straight to DONE on the next edge with overflow = 1 and q = r = 0,
// and never raises busy. When the macro is undefined, overflow is tied to 0
// and every division runs for N cycles, giving the truncated quotient.
//
// Parameters:
//   N          divisor / quotient / remainder width (dividend is 2N)
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request to begin a division
//   z          dividend, 2N bits, unsigned
//   d          divisor, N bits, unsigned
//   q          quotient, N bits
//   r          remainder, N bits
//   busy       high exactly while in CALC
//   done       result valid
//   overflow   quotient does not fit (only with DIV_OVF_CHECK_EN)
//   dbg_state  current controller state, for observation only
// -----------------------------------------------------------------------------
module bit_serial_divider
    import div_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] z,
    input  logic [N-1:0]   d,
    output logic [N-1:0]   q,
    output logic [N-1:0]   r,
    output logic           busy,
    output logic           done,
    output logic           overflow,
    output div_state_e     dbg_state
);

    // Number of CALC cycles, one per quotient bit.
    localparam logic [N-1:0] CNT_LOAD = N'(N);
    localparam logic [N-1:0] CNT_LAST = N'(1);

    div_state_e     state_q, state_d;
    logic [2*N-1:0] acc_q,   acc_d;    // {partial remainder, dividend/quotient}
    logic [N-1:0]   dvsr_q,  dvsr_d;
    logic [N-1:0]   count_q, count_d;
    logic [N-1:0]   quo_q,   quo_d;
    logic [N-1:0]   rem_q,   rem_d;
    logic           done_q,  done_d;

    logic [N-1:0]   step_rem;
    logic [N-1:0]   step_quo;
    logic           accept;

`ifdef DIV_OVF_CHECK_EN
    logic           ovf_q, ovf_d;
    logic           ovf_hit;

    // The quotient fits in N bits only when the upper half of the dividend
    // is strictly below the divisor. d == 0 always fails this test.
    assign ovf_hit = (z[2*N-1:N] >= d);
`endif

    // -------------------------------------------------------------------------
    // Datapath step
    // -------------------------------------------------------------------------
    div_step #(
        .N (N)
    ) u_step (
        .rem_i (acc_q[2*N-1:N]),
        .quo_i (acc_q[N-1:0]),
        .d_i   (dvsr_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // A new operation may only begin from an idle or finished controller.
    assign accept = start && (state_q == IDLE || state_q == DONE);

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        dvsr_d  = dvsr_q;
        count_d = count_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = done_q;
`ifdef DIV_OVF_CHECK_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = CALC;
                    acc_d   = z;
                    dvsr_d  = d;
                    count_d = CNT_LOAD;
                    done_d  = 1'b0;
`ifdef DIV_OVF_CHECK_EN
                    ovf_d   = 1'b0;
                    if (ovf_hit) begin
                        // Skip the iterations entirely and report overflow.
                        state_d = DONE;
                        acc_d   = '0;
                        count_d = '0;
                        quo_d   = '0;
                        rem_d   = '0;
                        done_d  = 1'b1;
                        ovf_d   = 1'b1;
                    end
`endif
                end
            end

            CALC: begin
                acc_d   = {step_rem, step_quo};
                count_d = count_q - 1'b1;
                if (count_q == CNT_LAST) begin
                    // This edge produces the final quotient bit.
                    state_d = DONE;
                    quo_d   = step_quo;
                    rem_d   = step_rem;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            dvsr_q  <= '0;
            count_q <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dvsr_q  <= dvsr_d;
            count_q <= count_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

`ifdef DIV_OVF_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // q and r come from dedicated result registers, so they stay stable while
    // a following division is iterating in acc_q.
    assign q         = quo_q;
    assign r         = rem_q;
    assign busy      = (state_q == CALC);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule : bit_serial_divider

// File: tb/tb_bit_serial_divider.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_divider
// Directed-vector bench for bit_serial_divider at N = 8. Inputs are driven and
// outputs sampled on the falling clock edge. Expected values are hand-computed
// constants.
// -----------------------------------------------------------------------------
module tb_bit_serial_divider;
    import div_pkg::*;

    localparam int N = 8;

    // ---------------------------------------------------------------- clock/reset
    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] z;
    logic [N-1:0]   d;
    logic [N-1:0]   q;
    logic [N-1:0]   r;
    logic           busy;
    logic           done;
    logic           overflow;
    div_state_e     dbg_state;

    always #5 clk = ~clk;

    bit_serial_divider #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .z         (z),
        .d         (d),
        .q         (q),
        .r         (r),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    // ---------------------------------------------------------------- scoreboard
    int              n_vec = 0;
    int              n_err = 0;
    logic [2*N-1:0]  exp_q[$];   // expected {q, r} per launched division

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- drivers
    // Called at a falling edge. Launches one division and follows it to done.
    // If glitch_at > 0, a second start (z=50, d=5) is pulsed after that many
    // cycles of CALC; it must be ignored.
    task automatic run_div(input logic [2*N-1:0] zz, input logic [N-1:0] dd,
                           input logic [N-1:0] eq, input logic [N-1:0] er,
                           input int glitch_at, input string tag);
        int             cycles;
        int             busy_cnt;
        logic [2*N-1:0] exp_qr;
        start = 1'b1;
        z     = zz;
        d     = dd;
        exp_q.push_back({eq, er});
        @(negedge clk);
        start = 1'b0;
        // One edge after acceptance: iterating, done and overflow cleared.
        check({tag, "_busy_first"}, 32'(busy), 32'd1);
        check({tag, "_done_clr"},   32'(done), 32'd0);
        check({tag, "_ovf_clr"},    32'(overflow), 32'd0);
        cycles   = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && cycles < 20) begin
            if (glitch_at > 0 && cycles == glitch_at) begin
                start = 1'b1;
                z     = 16'd50;
                d     = 8'd5;
            end
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (busy) busy_cnt++;
        end
        check({tag, "_latency"},  32'(cycles),   32'd8);
        check({tag, "_busy_cyc"}, 32'(busy_cnt), 32'd8);
        check({tag, "_done"},     32'(done),     32'd1);
        check({tag, "_busy_end"}, 32'(busy),     32'd0);
        check({tag, "_ovf"},      32'(overflow), 32'd0);
        exp_qr = exp_q.pop_front();
        check({tag, "_q"}, 32'(q), 32'(exp_qr[2*N-1:N]));
        check({tag, "_r"}, 32'(r), 32'(exp_qr[N-1:0]));
    endtask

    // Launches a division that must be rejected as an overflow in one cycle.
    task automatic run_ovf(input logic [2*N-1:0] zz, input logic [N-1:0] dd,
                           input string tag);
        start = 1'b1;
        z     = zz;
        d     = dd;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done"}, 32'(done),     32'd1);
        check({tag, "_ovf"},  32'(overflow), 32'd1);
        check({tag, "_q"},    32'(q),        32'd0);
        check({tag, "_r"},    32'(r),        32'd0);
        check({tag, "_busy"}, 32'(busy),     32'd0);
        check({tag, "_st"},   32'(dbg_state), 32'(DONE));
        @(negedge clk);
        check({tag, "_busy2"}, 32'(busy), 32'd0);
        check({tag, "_hold"},  32'(done), 32'd1);
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        int done_seen;
        rst_n = 1'b0;
        start = 1'b0;
        z     = '0;
        d     = '0;
        #2;
        check("rst_q",    32'(q),        32'd0);
        check("rst_r",    32'(r),        32'd0);
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_done", 32'(done),     32'd0);
        check("rst_ovf",  32'(overflow), 32'd0);
        check("rst_st",   32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 100 / 7 = 14 r 2
        run_div(16'd100, 8'd7, 8'd14, 8'd2, 0, "basic");
        repeat (2) @(negedge clk);
        check("basic_hold_done", 32'(done), 32'd1);
        check("basic_hold_q",    32'(q),    32'd14);
        check("basic_hold_r",    32'(r),    32'd2);

        // 0x06FF = 1791 = 7 * 255 + 6, largest quotient that fits
        run_div(16'h06FF, 8'd7, 8'd255, 8'd6, 0, "maxq");

`ifdef DIV_OVF_CHECK_EN
        // 0x0700 / 7 = 256 does not fit; d = 0 always overflows
        run_ovf(16'h0700, 8'd7, "ovf_big");
        run_ovf(16'd100,  8'd0, "ovf_d0");
`endif

        // Start pulsed mid-operation must not disturb the running division.
        run_div(16'd100, 8'd7, 8'd14, 8'd2, 3, "ignore");

        // Start held from DONE: restart on the same edge, 255 / 16 = 15 r 15.
        run_div(16'd255, 8'd16, 8'd15, 8'd15, 0, "b2b");

        // Reset asserted partway through a division.
        @(negedge clk);
        start = 1'b1;
        z     = 16'd100;
        d     = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_q",    32'(q),        32'd0);
        check("mid_rst_r",    32'(r),        32'd0);
        check("mid_rst_busy", 32'(busy),     32'd0);
        check("mid_rst_done", 32'(done),     32'd0);
        check("mid_rst_ovf",  32'(overflow), 32'd0);
        check("mid_rst_st",   32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("mid_rst_quiet", 32'(done_seen), 32'd0);

        // 40200 / 201 = 200 r 0
        run_div(16'd40200, 8'd201, 8'd200, 8'd0, 0, "post_rst");

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bit_serial_divider
